// File: rtl/spi_display_pkg.sv
// ---------------------------------------------------------------------------
// spi_display_pkg
//   Shared definitions for the 320x240 RGB565 SPI display receiver:
//   command opcodes, the command-decode FSM state type, default geometry and
//   the linear pixel address helper.
// ---------------------------------------------------------------------------
package spi_display_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;

  typedef enum logic [3:0] {
    ST_CMD,
    ST_MADCTL_P,
    ST_COLMOD_P,
    ST_CASET_P0,
    ST_CASET_P1,
    ST_CASET_P2,
    ST_CASET_P3,
    ST_PASET_P0,
    ST_PASET_P1,
    ST_PASET_P2,
    ST_PASET_P3,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_IGNORE
  } RX_STATE_T;

  // row*320 + col as a constant shift-add: 320 = 256 + 64.
  function automatic logic [16:0] pixel_addr_320(input logic [7:0] row,
                                                 input logic [8:0] col);
    logic [16:0] row_w;
    row_w = {9'd0, row};
    return (row_w << 8) + (row_w << 6) + {8'd0, col};
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// ---------------------------------------------------------------------------
// spi_byte_rx
//   SPI mode-0 byte deserialiser running entirely in the CLK_50MHz domain.
//   All four SPI pins pass through SYNC_STAGES (>= 2) flops; a rising SCK is
//   the synced value going 0 -> 1. Bits shift in MSB first while synced CS is
//   low; the 8th bit produces a one-cycle byte_valid on the following clock
//   together with the byte and the DC level sampled alongside bit 0.
//   Synced CS high clears the bit counter, dropping any partial byte.
//
// Ports
//   CLK_50MHz   in   system clock
//   RESET       in   synchronous, active-high
//   spi_cs      in   chip select, active-low (asynchronous pin)
//   spi_dc      in   data/command select (asynchronous pin)
//   spi_sdi     in   serial data (asynchronous pin)
//   spi_sck     in   serial clock, idle low (asynchronous pin)
//   rx_byte     out  assembled byte
//   rx_dc       out  DC level belonging to rx_byte
//   byte_valid  out  one-cycle strobe, rx_byte/rx_dc valid
// ---------------------------------------------------------------------------
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_50MHz,
  input  logic       RESET,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_sdi,
  input  logic       spi_sck,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       byte_valid
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic                   sck_prev;

  logic cs_s, dc_s, sdi_s, sck_s, sck_rise;

  logic [6:0] shift_q;
  logic [2:0] bit_cnt;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours (the sync chains
  // depend on this to actually delay by one stage each).
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      cs_sync  <= '1;            // deselected while in reset
      dc_sync  <= '0;
      sdi_sync <= '0;
      sck_sync <= '0;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  spi_cs};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0],  spi_dc};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      sck_prev <= sck_s;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      rx_dc      <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_q <= {shift_q[5:0], sdi_s};
        if (bit_cnt == 3'd7) begin
          bit_cnt    <= '0;
          rx_byte    <= {shift_q, sdi_s};
          rx_dc      <= dc_s;
          byte_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_display_rx_320x240.sv
// ---------------------------------------------------------------------------
// spi_display_rx_320x240
//   Peripheral-side model of a 320x240 RGB565 SPI display controller.
//   Decodes NOP, MADCTL, COLMOD, CASET, PASET and RAMWR from the byte stream
//   and turns RAMWR pixel pairs into framebuffer writes with window
//   auto-increment. Parameter bytes may span CS frames; any command byte
//   aborts whatever parameter/pixel sequence was in progress.
//
//   Build option: define ADDR_CLIP_EN to suppress writes outside
//   H_RES x V_RES (and flag FRAME_ERR). Without it every pixel is written,
//   and WA may exceed the visible area.
//
// Ports
//   CLK_50MHz   in   system clock
//   RESET       in   synchronous, active-high
//   SPI_CS      in   chip select, active-low
//   SPI_DC      in   0 = command byte, 1 = data byte
//   SPI_SDI     in   serial data, MSB first
//   SPI_SCK     in   serial clock, idle low, <= CLK_50MHz/4
//   WA          out  pixel address row*H_RES+col
//   WD          out  RGB565 pixel
//   WE          out  one-cycle write strobe
//   MADCTL_REG  out  last MADCTL parameter
//   COLMOD_REG  out  last COLMOD parameter
//   FRAME_ERR   out  sticky: unknown command, inverted window, clipped pixel
// ---------------------------------------------------------------------------
module spi_display_rx_320x240
  import spi_display_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF
) (
  input  logic        CLK_50MHz,
  input  logic        RESET,
  input  logic        SPI_CS,
  input  logic        SPI_DC,
  input  logic        SPI_SDI,
  input  logic        SPI_SCK,
  output logic [16:0] WA,
  output logic [15:0] WD,
  output logic        WE,
  output logic [7:0]  MADCTL_REG,
  output logic [7:0]  COLMOD_REG,
  output logic        FRAME_ERR
);

  // The cursor is 9 bits of column and 8 bits of row; larger geometries
  // cannot be addressed.
  if (H_RES > 512 || V_RES > 256) begin : g_bad_geometry
    $error("spi_display_rx_320x240: H_RES/V_RES exceed cursor width");
  end

  // ---------------------------------------------------------------- bytes
  logic [7:0] rx_byte;
  logic       rx_dc;
  logic       byte_valid;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .CLK_50MHz  (CLK_50MHz),
    .RESET      (RESET),
    .spi_cs     (SPI_CS),
    .spi_dc     (SPI_DC),
    .spi_sdi    (SPI_SDI),
    .spi_sck    (SPI_SCK),
    .rx_byte    (rx_byte),
    .rx_dc      (rx_dc),
    .byte_valid (byte_valid)
  );

  // ---------------------------------------------------------------- FSM
  RX_STATE_T state, state_nxt;
  logic      bad_opcode;

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) state <= ST_CMD;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default before any branch,
  // otherwise paths that skip an assignment would infer latches.
  always_comb begin
    state_nxt  = state;
    bad_opcode = 1'b0;
    if (byte_valid) begin
      if (!rx_dc) begin
        case (rx_byte)
          CMD_NOP:    state_nxt = ST_CMD;
          CMD_MADCTL: state_nxt = ST_MADCTL_P;
          CMD_COLMOD: state_nxt = ST_COLMOD_P;
          CMD_CASET:  state_nxt = ST_CASET_P0;
          CMD_PASET:  state_nxt = ST_PASET_P0;
          CMD_RAMWR:  state_nxt = ST_RAMWR_HI;
          default: begin
            state_nxt  = ST_IGNORE;
            bad_opcode = 1'b1;
          end
        endcase
      end else begin
        case (state)
          ST_MADCTL_P: state_nxt = ST_CMD;
          ST_COLMOD_P: state_nxt = ST_CMD;
          ST_CASET_P0: state_nxt = ST_CASET_P1;
          ST_CASET_P1: state_nxt = ST_CASET_P2;
          ST_CASET_P2: state_nxt = ST_CASET_P3;
          ST_CASET_P3: state_nxt = ST_CMD;
          ST_PASET_P0: state_nxt = ST_PASET_P1;
          ST_PASET_P1: state_nxt = ST_PASET_P2;
          ST_PASET_P2: state_nxt = ST_PASET_P3;
          ST_PASET_P3: state_nxt = ST_CMD;
          ST_RAMWR_HI: state_nxt = ST_RAMWR_LO;
          ST_RAMWR_LO: state_nxt = ST_RAMWR_HI;
          default:     state_nxt = state;   // CMD, IGNORE drop data bytes
        endcase
      end
    end
  end

  // ----------------------------------------------------- window / cursor
  // Only the bits surviving truncation are kept from the 16-bit window
  // parameters: bit 8 of the column high bytes, the full low bytes.
  logic       par_start_hi;   // SC[8] (column only)
  logic [7:0] par_start_lo;   // SC[7:0] / SP[7:0]
  logic       par_end_hi;     // EC[8] (column only)

  logic [8:0] win_sc, win_ec;
  logic [7:0] win_sp, win_ep;
  logic [8:0] cur_col;
  logic [7:0] cur_row;
  logic [7:0] pix_hi;

  logic [8:0]  caset_start, caset_end;
  logic [16:0] cur_addr;

  assign caset_start = {par_start_hi, par_start_lo};
  assign caset_end   = {par_end_hi, rx_byte};

  if (H_RES == 320) begin : g_addr_320
    assign cur_addr = pixel_addr_320(cur_row, cur_col);
  end else begin : g_addr_generic
    assign cur_addr = ({9'd0, cur_row} * 17'(H_RES)) + {8'd0, cur_col};
  end

`ifdef ADDR_CLIP_EN
  logic pix_oob;
  assign pix_oob = (cur_col >= 9'(H_RES)) || ({1'b0, cur_row} >= 9'(V_RES));
`endif

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      WA           <= '0;
      WD           <= '0;
      WE           <= 1'b0;
      MADCTL_REG   <= 8'h00;
      COLMOD_REG   <= 8'h00;
      FRAME_ERR    <= 1'b0;
      par_start_hi <= 1'b0;
      par_start_lo <= '0;
      par_end_hi   <= 1'b0;
      win_sc       <= 9'd0;
      win_ec       <= 9'(H_RES - 1);
      win_sp       <= 8'd0;
      win_ep       <= 8'(V_RES - 1);
      cur_col      <= '0;
      cur_row      <= '0;
      pix_hi       <= '0;
    end else begin
      WE <= 1'b0;
      if (bad_opcode) FRAME_ERR <= 1'b1;

      if (byte_valid && rx_dc) begin
        case (state)
          ST_MADCTL_P: MADCTL_REG <= rx_byte;
          ST_COLMOD_P: COLMOD_REG <= rx_byte;

          ST_CASET_P0: par_start_hi <= rx_byte[0];
          ST_CASET_P1,
          ST_PASET_P1: par_start_lo <= rx_byte;
          ST_CASET_P2: par_end_hi   <= rx_byte[0];
          ST_CASET_P3: begin
            win_sc  <= caset_start;
            win_ec  <= caset_end;
            cur_col <= caset_start;
            if (caset_start > caset_end) FRAME_ERR <= 1'b1;
          end
          ST_PASET_P3: begin
            win_sp  <= par_start_lo;
            win_ep  <= rx_byte;
            cur_row <= par_start_lo;
            if (par_start_lo > rx_byte) FRAME_ERR <= 1'b1;
          end

          ST_RAMWR_HI: pix_hi <= rx_byte;
          ST_RAMWR_LO: begin
            WA <= cur_addr;
            WD <= {pix_hi, rx_byte};
`ifdef ADDR_CLIP_EN
            if (pix_oob) FRAME_ERR <= 1'b1;
            else         WE        <= 1'b1;
`else
            WE <= 1'b1;
`endif
            // Raster advance inside the window; an inverted column window
            // simply runs the 9-bit counter round until it meets EC.
            if (cur_col == win_ec) begin
              cur_col <= win_sc;
              cur_row <= (cur_row == win_ep) ? win_sp : cur_row + 8'd1;
            end else begin
              cur_col <= cur_col + 9'd1;
            end
          end

          default: ;   // PASET_P0/P2 carry no retained bits; CMD/IGNORE drop data
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_display_rx_320x240.sv
// ---------------------------------------------------------------------------
// tb_spi_display_rx_320x240
//   Directed self-checking bench for spi_display_rx_320x240. SPI traffic is
//   bit-banged at CLK_50MHz/6; a monitor records every WE into queues that
//   each scenario compares against hand-computed addresses and pixels.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_display_rx_320x240;

  logic        CLK_50MHz = 1'b0;
  logic        RESET     = 1'b1;
  logic        SPI_CS    = 1'b1;
  logic        SPI_DC    = 1'b0;
  logic        SPI_SDI   = 1'b0;
  logic        SPI_SCK   = 1'b0;
  logic [16:0] WA;
  logic [15:0] WD;
  logic        WE;
  logic [7:0]  MADCTL_REG;
  logic [7:0]  COLMOD_REG;
  logic        FRAME_ERR;

  spi_display_rx_320x240 dut (
    .CLK_50MHz  (CLK_50MHz),
    .RESET      (RESET),
    .SPI_CS     (SPI_CS),
    .SPI_DC     (SPI_DC),
    .SPI_SDI    (SPI_SDI),
    .SPI_SCK    (SPI_SCK),
    .WA         (WA),
    .WD         (WD),
    .WE         (WE),
    .MADCTL_REG (MADCTL_REG),
    .COLMOD_REG (COLMOD_REG),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #10 CLK_50MHz = ~CLK_50MHz;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [16:0] wa_q[$];
  logic [15:0] wd_q[$];
  always @(negedge CLK_50MHz) begin
    if (WE === 1'b1) begin
      wa_q.push_back(WA);
      wd_q.push_back(WD);
    end
  end

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  // Sends the first n bits (MSB first) of b.
  task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
    @(negedge CLK_50MHz);
    SPI_CS = 1'b0;
    SPI_DC = dc;
    for (int i = 0; i < n; i++) begin
      SPI_SDI = b[7-i];
      repeat (3) @(negedge CLK_50MHz);
      SPI_SCK = 1'b1;
      repeat (3) @(negedge CLK_50MHz);
      SPI_SCK = 1'b0;
    end
    repeat (2) @(negedge CLK_50MHz);
  endtask

  task automatic cmd(input logic [7:0] b);
    spi_bits(b, 1'b0, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    spi_bits(b, 1'b1, 8);
  endtask

  task automatic cs_release();
    @(negedge CLK_50MHz);
    SPI_CS = 1'b1;
    repeat (6) @(negedge CLK_50MHz);
  endtask

  task automatic settle();
    repeat (12) @(negedge CLK_50MHz);
  endtask

  task automatic set_window(input logic [15:0] sc, input logic [15:0] ec,
                            input logic [15:0] sp, input logic [15:0] ep);
    cmd(8'h2A); dat(sc[15:8]); dat(sc[7:0]); dat(ec[15:8]); dat(ec[7:0]);
    cmd(8'h2B); dat(sp[15:8]); dat(sp[7:0]); dat(ep[15:8]); dat(ep[7:0]);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, " WA"},        32'(WA),         32'h0);
    check({pfx, " WD"},        32'(WD),         32'h0);
    check({pfx, " WE"},        32'(WE),         32'h0);
    check({pfx, " MADCTL"},    32'(MADCTL_REG), 32'h0);
    check({pfx, " COLMOD"},    32'(COLMOD_REG), 32'h0);
    check({pfx, " FRAME_ERR"}, 32'(FRAME_ERR),  32'h0);
  endtask

  logic [16:0] exp_wa3[5] = '{17'd3518, 17'd3519, 17'd3838, 17'd3839, 17'd3518};

  initial begin
    // ---- reset
    repeat (4) @(negedge CLK_50MHz);
    RESET = 1'b0;
    @(negedge CLK_50MHz);
    check_reset_state("reset");

    // ---- MADCTL / COLMOD
    clear_writes();
    cmd(8'h36); dat(8'h20);
    cmd(8'h3A); dat(8'h55);
    settle();
    check("madctl value", 32'(MADCTL_REG), 32'h20);
    check("colmod value", 32'(COLMOD_REG), 32'h55);
    check("cfg frame_err", 32'(FRAME_ERR), 32'h0);
    check("cfg no writes", 32'(wa_q.size()), 32'd0);

    // ---- single pixel at (5,3)
    clear_writes();
    set_window(16'd5, 16'd5, 16'd3, 16'd3);
    cmd(8'h2C); dat(8'hF8); dat(8'h00);
    settle();
    check("px1 count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("px1 WA", 32'(wa_q[0]), 32'd965);
      check("px1 WD", 32'(wd_q[0]), 32'hF800);
    end

    // ---- window 318..319 x 10..11, five pixels, row wraps
    clear_writes();
    set_window(16'd318, 16'd319, 16'd10, 16'd11);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) begin
      dat(8'h12); dat(8'(8'h30 + i));
    end
    settle();
    check("win count", 32'(wa_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wa_q.size()) begin
        check($sformatf("win WA[%0d]", i), 32'(wa_q[i]), 32'(exp_wa3[i]));
        check($sformatf("win WD[%0d]", i), 32'(wd_q[i]), 32'(16'h1230 + 16'(i)));
      end
    end
    check("win frame_err", 32'(FRAME_ERR), 32'h0);

    // ---- partial low byte discarded by CS high
    clear_writes();
    set_window(16'd7, 16'd9, 16'd2, 16'd2);
    cmd(8'h2C); dat(8'hAB);
    spi_bits(8'hFF, 1'b1, 5);
    cs_release();
    settle();
    check("partial no write", 32'(wa_q.size()), 32'd0);
    dat(8'h1F);
    settle();
    check("partial count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("partial WA", 32'(wa_q[0]), 32'd647);
      check("partial WD", 32'(wd_q[0]), 32'hAB1F);
    end
    check("partial frame_err", 32'(FRAME_ERR), 32'h0);

    // ---- unknown opcode, data ignored, next pixel normal
    clear_writes();
    cmd(8'h99); dat(8'h01); dat(8'h02); dat(8'h03);
    settle();
    check("badop frame_err", 32'(FRAME_ERR), 32'h1);
    check("badop madctl", 32'(MADCTL_REG), 32'h20);
    check("badop colmod", 32'(COLMOD_REG), 32'h55);
    check("badop no writes", 32'(wa_q.size()), 32'd0);
    cmd(8'h2C); dat(8'h55); dat(8'h55);
    settle();
    check("badop px count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("badop px WA", 32'(wa_q[0]), 32'd648);   // cursor advanced 7 -> 8
      check("badop px WD", 32'(wd_q[0]), 32'h5555);
    end

    // ---- column 320 (outside visible area)
    clear_writes();
    set_window(16'h0140, 16'h0140, 16'd0, 16'd0);
    cmd(8'h2C); dat(8'hC3); dat(8'h3C);
    settle();
`ifdef ADDR_CLIP_EN
    check("clip no write", 32'(wa_q.size()), 32'd0);
    check("clip frame_err", 32'(FRAME_ERR), 32'h1);
`else
    check("oob count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("oob WA", 32'(wa_q[0]), 32'd320);
      check("oob WD", 32'(wd_q[0]), 32'hC33C);
    end
`endif

    // ---- RESET in the middle of a pixel
    clear_writes();
    cmd(8'h2C); dat(8'h77);
    spi_bits(8'hFF, 1'b1, 4);
    RESET = 1'b1;
    SPI_CS = 1'b1;
    SPI_SCK = 1'b0;
    repeat (3) @(negedge CLK_50MHz);
    RESET = 1'b0;
    @(negedge CLK_50MHz);
    check_reset_state("midreset");
    settle();
    check("midreset no write", 32'(wa_q.size()), 32'd0);
    cmd(8'h2C); dat(8'h01); dat(8'h02);
    settle();
    check("postreset count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) begin
      check("postreset WA", 32'(wa_q[0]), 32'd0);
      check("postreset WD", 32'(wd_q[0]), 32'h0102);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_display_rx_320x240.md
Name: spi_display_rx_320x240

Overview:
- SPI peripheral-side model of a 320x240 RGB565 display controller.
- Deserialises the 4-wire write-only stream (CS, DC, SDI, SCK) and decodes MADCTL, COLMOD, CASET, PASET and RAMWR.
- Emits framebuffer pixel writes (WA, WD, WE) with window auto-increment.
- Sits on the far end of the display PMOD link: loopback verification target for the display driver, and front end of an on-chip framebuffer/VGA path.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection.
- H_RES, 320, columns; linear address multiplier.
- V_RES, 240, rows.

Ports:
- CLK_50MHz  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- SPI_CS  in  1  chip select, active-low.
- SPI_DC  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- SPI_SDI  in  1  serial data, MSB first, sampled on SCK rising edge.
- SPI_SCK  in  1  serial clock, idle low; at most CLK_50MHz/4.
- WA  out  17  pixel address, row*H_RES+col.
- WD  out  16  RGB565 pixel.
- WE  out  1  one-cycle write strobe.
- MADCTL_REG  out  8  last MADCTL parameter.
- COLMOD_REG  out  8  last COLMOD parameter.
- FRAME_ERR  out  1  sticky; unknown command or window error seen.

Behaviour:
- Reset values: WA=0, WD=0, WE=0, MADCTL_REG=0x00, COLMOD_REG=0x00, FRAME_ERR=0. Window: col SC=0, EC=319; row SP=0, EP=239. Cursor at (0,0). FSM in CMD.
- Inputs pass through SYNC_STAGES flops; an SCK rising edge is detected as previous synced 0 and current synced 1.
- Bit capture happens only while synced CS=0. On each SCK rise, SDI shifts into an 8-bit register and the bit counter increments.
- After 8 bits, byte_valid pulses for 1 cycle on the next clock, carrying byte and DC.
- Synced CS going high clears the bit counter and discards any partial byte. FSM state and the pending pixel high byte are retained, so parameters may span CS frames.
- Any byte with DC=0 is a command. It aborts the current parameter/pixel sequence, discards a pending high byte and jumps to the state for that opcode.
- Opcodes: 0x00 NOP stays in CMD; 0x36 goes to MADCTL_P; 0x3A to COLMOD_P; 0x2A to CASET_P0; 0x2B to PASET_P0; 0x2C to RAMWR_HI.
- Any other opcode sets FRAME_ERR and goes to IGNORE, which drops data bytes until the next command.
- MADCTL_P / COLMOD_P: the first data byte loads the register, then the FSM returns to CMD.
- CASET_P0..P3: bytes are SC[15:8], SC[7:0], EC[15:8], EC[7:0]. On P3, commit SC/EC, set cursor col=SC, go to CMD.
- PASET_P0..P3: same byte order for SP/EP. Commit on P3, set cursor row=SP.
- Data bytes arriving in CMD are ignored.
- RAMWR_HI latches the high byte and goes to RAMWR_LO.
- RAMWR_LO: on the cycle after its byte_valid, WE=1, WD={hi,lo}, WA=row*H_RES+col. FSM returns to RAMWR_HI.
- Latency is 1 clock from the low-byte byte_valid to WE.
- Cursor advance after each write:
  - if col==EC, set col=SC; then if row==EP set row=SP, else row+1.
  - otherwise col+1.
- Column counter is 9 bits and row counter is 8 bits. Window values are truncated to these widths at commit.
- If SC>EC or SP>EP at commit, set FRAME_ERR and still commit. Col then advances until it wraps at 511.
- The multiply is a constant shift-add (row<<8 + row<<6 + col), 17 bits.
- RESET mid-byte or mid-pixel returns all state to reset values on the same edge. No WE is issued.

Optional Feature:
- Macro ADDR_CLIP_EN.
- Defined: a pixel whose col>=H_RES or row>=V_RES is not written (WE stays 0) and sets FRAME_ERR. The cursor still advances.
- Undefined: WE is always issued. WA may exceed 76799 and the downstream memory must tolerate it.

Decomposition:
- Package spi_display_pkg:
  - opcode constants CMD_NOP, CMD_MADCTL, CMD_COLMOD, CMD_CASET, CMD_PASET, CMD_RAMWR;
  - FSM enum RX_STATE_T;
  - H_RES_DEF, V_RES_DEF.
- Sub-module spi_byte_rx: synchronisers, SCK edge detect, shift register and bit counter. Outputs byte[7:0], dc, byte_valid.
- Top level holds the decode FSM, window registers, cursor and address generation.

Test Plan:
- Reset then MADCTL 0x36+0x20 and COLMOD 0x3A+0x55 -> MADCTL_REG=0x20, COLMOD_REG=0x55, FRAME_ERR=0, WE never asserted.
- CASET 0,5,0,5; PASET 0,3,0,3; RAMWR 0xF8,0x00 -> single WE with WA=965, WD=0xF800.
- Window col 318..319, row 10..11, RAMWR of 5 pixels -> WA sequence 3518, 3519, 3838, 3839, 3518 (row wraps).
- CS raised after 5 bits of a pixel low byte, then a fresh low byte 0x1F -> one WE with WD={hi,0x1F}; partial bits discarded.
- Opcode 0x99 followed by 3 data bytes, then RAMWR -> FRAME_ERR=1, no register change; next pixel writes normally.
- ADDR_CLIP_EN defined, CASET 0x01,0x40 (320) for both SC and EC, RAMWR 1 pixel -> WE=0, FRAME_ERR=1. Macro undefined -> WE=1, WA=row*320+320.
